// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared types and width helpers for the PageRank reducer.
//   state_t    - reducer FSM state (accepting terms / result pending)
//   sum_width  - accumulator width that holds n * (2^nbits - 1) exactly
//   idx_width  - width of a row index / term counter for n rows
package pagerank_pkg;

    typedef enum logic {
        STATE_ACC = 1'b0,
        STATE_OUT = 1'b1
    } state_t;

    localparam int DEF_NBITS = 8;
    localparam int DEF_N     = 8;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int sum_width(input int nbits, input int n);
        return nbits + $clog2(n);
    endfunction

    localparam int DEF_SUMW = sum_width(DEF_NBITS, DEF_N);
    localparam int DEF_IDXW = idx_width(DEF_N);

endpackage

// File: rtl/pagerank_accum_reg.sv
// pagerank_accum_reg: running-sum register for the PageRank reducer.
//   clk     - clock
//   reset   - asynchronous active-low reset, zeroes the sum
//   clear   - synchronous zero, has priority over add_en
//   add_en  - add add_val into the sum this cycle
//   add_val - zero-extended term to add
//   acc     - current sum
module pagerank_accum_reg #(
    parameter int width = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic [width-1:0] add_val,
    output logic [width-1:0] acc
);

    logic [width-1:0] acc_q;
    logic [width-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + add_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pagerank_reducer.sv
// pagerank_reducer: sums every n accepted partial products into one rank entry
// and hands it out tagged with its row index.
//   clk      - clock
//   reset    - asynchronous active-low reset
//   clear    - abort the partial sum (ignored while a result is pending)
//   in_data  - unsigned partial product; in_val/in_rdy handshake
//   out_data - completed sum; out_idx its row; out_val/out_rdy handshake
//   busy     - a partial sum is in progress or a result is pending
module pagerank_reducer
    import pagerank_pkg::*;
#(
    parameter int nbits = DEF_NBITS,
    parameter int n     = DEF_N,
    localparam int SUMW = sum_width(nbits, n),
    localparam int IDXW = idx_width(n)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [nbits-1:0] in_data,
    input  logic            in_val,
    output logic            in_rdy,
    output logic [SUMW-1:0] out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_val,
    input  logic            out_rdy,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [SUMW-1:0] out_data_q, out_data_d;

    logic [SUMW-1:0] acc;
    logic [SUMW-1:0] in_ext;
    logic            acc_clr;
    logic            in_go;
    logic            out_go;
    logic            last;

    assign in_ext = {{(SUMW - nbits){1'b0}}, in_data};
    assign in_rdy  = (state_q == STATE_ACC) & ~clear;
    assign out_val = (state_q == STATE_OUT);
    assign in_go   = in_val & in_rdy;
    assign out_go  = out_val & out_rdy;
    assign last    = (cnt_q == IDXW'(n - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        acc_clr    = 1'b0;
        unique case (state_q)
            STATE_ACC: begin
                if (clear) begin
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end else if (in_go) begin
                    if (last) begin
                        // Final term bypasses the accumulator straight into the output register.
                        out_data_d = acc + in_ext;
                        cnt_d      = '0;
                        acc_clr    = 1'b1;
                        state_d    = STATE_OUT;
                    end else begin
                        cnt_d = cnt_q + IDXW'(1);
                    end
                end
            end
            STATE_OUT: begin
                if (out_go) begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = STATE_ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= STATE_ACC;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    pagerank_accum_reg #(
        .width (SUMW)
    ) u_accum (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clr),
        .add_en  (in_go),
        .add_val (in_ext),
        .acc     (acc)
    );

    assign out_data = out_data_q;
    assign out_idx  = idx_q;
    assign busy     = (cnt_q != '0) | out_val;

endmodule

// File: tb/tb_pagerank_reducer.sv
module tb_pagerank_reducer;

    localparam int NBITS = 8;
    localparam int N     = 8;
    localparam int SUMW  = 11;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [NBITS-1:0] in_data = '0;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [SUMW-1:0]  out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic             busy;

    pagerank_reducer #(
        .nbits (NBITS),
        .n     (N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_data  (in_data),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference model state
    int exp_data_q[$];
    int exp_idx_q[$];
    int  macc = 0;
    int  mcnt = 0;
    int  midx = 0;
    bit  pend = 1'b0;
    bit  accepted = 1'b0;
    int  last_data = -1;
    int  last_idx = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already driven; checks outputs mid low phase,
    // predicts what the coming posedge does, then returns at the next negedge.
    task automatic tick();
        #1;
        check_eq("in_rdy", in_rdy, !pend && !clear);
        check_eq("out_val", out_val, pend);
        check_eq("busy", busy, (mcnt != 0) || pend);
        accepted = 1'b0;
        if (pend) begin
            check_eq("out_data", out_data, exp_data_q[0]);
            check_eq("out_idx", out_idx, exp_idx_q[0]);
            if (out_rdy) begin
                last_data = exp_data_q.pop_front();
                last_idx  = exp_idx_q.pop_front();
                pend = 1'b0;
            end
        end else if (clear) begin
            macc = 0;
            mcnt = 0;
        end else if (in_val) begin
            accepted = 1'b1;
            macc += int'(in_data);
            mcnt++;
            if (mcnt == N) begin
                exp_data_q.push_back(macc);
                exp_idx_q.push_back(midx);
                midx = (midx + 1) % N;
                macc = 0;
                mcnt = 0;
                pend = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [NBITS-1:0] d);
        bit done = 1'b0;
        in_val  = 1'b1;
        in_data = d;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (accepted) begin
                done = 1'b1;
                break;
            end
        end
        in_val = 1'b0;
        check_eq("send_timeout", done, 1'b1);
    endtask

    task automatic drain();
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!pend) break;
            tick();
        end
        check_eq("drain_timeout", pend, 1'b0);
    endtask

    // Asynchronous assertion mid low phase, synchronous release at a negedge.
    task automatic do_reset();
        clear = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_out_val", out_val, 1'b0);
        check_eq("rst_in_rdy", in_rdy, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_idx", out_idx, 0);
        pend = 1'b0;
        macc = 0;
        mcnt = 0;
        midx = 0;
        exp_data_q.delete();
        exp_idx_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Basic sum 1..8
        out_rdy = 1'b1;
        for (int i = 1; i <= N; i++) send(NBITS'(i));
        drain();
        check_eq("basic_sum", last_data, 36);
        check_eq("basic_idx", last_idx, 0);

        // All-ones terms, full width
        for (int i = 0; i < N; i++) send(8'hFF);
        drain();
        check_eq("max_sum", last_data, 2040);
        check_eq("max_idx", last_idx, 1);

        // Seven more back-to-back sums carry the index through 7 and back to 0
        for (int s = 0; s < 7; s++) begin
            for (int j = 0; j < N; j++) send(NBITS'($urandom_range(0, 255)));
        end
        drain();
        check_eq("idx_wrap", last_idx, 0);

        // Backpressure: result held with in_val high, then input resumes after out_go
        out_rdy = 1'b0;
        for (int i = 1; i <= N; i++) send(NBITS'(3 * i));
        in_val  = 1'b1;
        in_data = 8'd7;
        repeat (5) tick();
        out_rdy = 1'b1;
        tick();
        check_eq("bp_sum", last_data, 108);
        tick();
        check_eq("bp_resume", accepted, 1'b1);
        in_val = 1'b0;
        for (int i = 0; i < N - 1; i++) send(8'd1);
        drain();
        check_eq("bp_next_sum", last_data, 14);

        // Clear mid-sum drops the partial sum and the term offered that cycle
        begin
            int idx_before;
            send(8'd3);
            send(8'd4);
            send(8'd5);
            idx_before = midx;
            clear   = 1'b1;
            in_val  = 1'b1;
            in_data = 8'd9;
            tick();
            clear  = 1'b0;
            in_val = 1'b0;
            check_eq("clr_busy", busy, 1'b0);
            for (int i = 0; i < N; i++) send(8'd2);
            drain();
            check_eq("clr_sum", last_data, 16);
            check_eq("clr_idx", last_idx, idx_before);
        end

        // Clear while a result is pending leaves it untouched
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) send(8'd10);
        clear = 1'b1;
        repeat (3) tick();
        out_rdy = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_out_sum", last_data, 80);

        // Reset mid-sum, then reset with a result pending
        for (int i = 0; i < 4; i++) send(8'd5);
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) send(8'd1);
        tick();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) send(8'd1);
        drain();
        check_eq("post_rst_sum", last_data, 8);
        check_eq("post_rst_idx", last_idx, 0);

        check_eq("queue_empty", exp_data_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
